// File: rtl/reset_sequencer.sv
// Staged reset release: waits out a hold period and a filtered PLL lock, then
// deasserts each active-low stage reset in index order, STAGE_DLY cycles apart.
module reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int LOCK_FILT   = 8,
    parameter int STAGE_DLY   = 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  sw_rst_req,
    output logic [NUM_STAGES-1:0] rst_stage_n,
    output logic                  seq_done,
    output logic [1:0]            seq_state
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int LOCK_W = (LOCK_FILT   > 1) ? $clog2(LOCK_FILT)   : 1;
    localparam int DLY_W  = (STAGE_DLY   > 1) ? $clog2(STAGE_DLY)   : 1;
    localparam int IDX_W  = (NUM_STAGES  > 1) ? $clog2(NUM_STAGES)  : 1;

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_LOCK_WAIT = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [HOLD_W-1:0]       hold_cnt_reg, hold_cnt_next;
    logic [LOCK_W-1:0]       lock_cnt_reg, lock_cnt_next;
    logic [DLY_W-1:0]        dly_cnt_reg, dly_cnt_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [NUM_STAGES-1:0]   stage_reg, stage_next;
    logic                    done_reg, done_next;
    logic                    sync1_reg, lock_s_reg;
    logic [NUM_STAGES-1:0]   release_mask;
    logic                    abort;

    // One-hot select of the stage being released this step; OR-ing it into the
    // stage register keeps the outputs thermometer-coded.
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_mask
        assign release_mask[gi] = (idx_reg == IDX_W'(gi));
    end

    assign abort = sw_rst_req ||
                   (!lock_s_reg && (state_reg == ST_RELEASE || state_reg == ST_RUN));

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        lock_cnt_next = lock_cnt_reg;
        dly_cnt_next  = dly_cnt_reg;
        idx_next      = idx_reg;
        stage_next    = stage_reg;
        done_next     = done_reg;

        if (abort) begin
            state_next    = ST_HOLD;
            hold_cnt_next = '0;
            lock_cnt_next = '0;
            dly_cnt_next  = '0;
            idx_next      = '0;
            stage_next    = '0;
            done_next     = 1'b0;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    stage_next = '0;
                    done_next  = 1'b0;
                    if (hold_cnt_reg == HOLD_W'(HOLD_CYCLES - 1)) begin
                        state_next    = ST_LOCK_WAIT;
                        hold_cnt_next = '0;
                    end else begin
                        hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                    end
                end
                ST_LOCK_WAIT: begin
                    if (!lock_s_reg) begin
                        lock_cnt_next = '0;
                    end else if (lock_cnt_reg == LOCK_W'(LOCK_FILT - 1)) begin
                        state_next    = ST_RELEASE;
                        lock_cnt_next = '0;
                        dly_cnt_next  = '0;
                        idx_next      = '0;
                    end else begin
                        lock_cnt_next = lock_cnt_reg + LOCK_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (dly_cnt_reg == DLY_W'(STAGE_DLY - 1)) begin
                        dly_cnt_next = '0;
                        stage_next   = stage_reg | release_mask;
                        if (idx_reg == IDX_W'(NUM_STAGES - 1)) begin
                            state_next = ST_RUN;
                            done_next  = 1'b1;
                        end else begin
                            idx_next = idx_reg + IDX_W'(1);
                        end
                    end else begin
                        dly_cnt_next = dly_cnt_reg + DLY_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_HOLD;
            hold_cnt_reg <= '0;
            lock_cnt_reg <= '0;
            dly_cnt_reg  <= '0;
            idx_reg      <= '0;
            stage_reg    <= '0;
            done_reg     <= 1'b0;
            sync1_reg    <= 1'b0;
            lock_s_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            lock_cnt_reg <= lock_cnt_next;
            dly_cnt_reg  <= dly_cnt_next;
            idx_reg      <= idx_next;
            stage_reg    <= stage_next;
            done_reg     <= done_next;
            sync1_reg    <= pll_locked;
            lock_s_reg   <= sync1_reg;
        end
    end

    assign rst_stage_n = stage_reg;
    assign seq_done    = done_reg;
    assign seq_state   = state_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with NUM_STAGES=3, HOLD_CYCLES=4,
// LOCK_FILT=3, STAGE_DLY=5; outputs are sampled 1 ns after each rising edge.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic [2:0] rst_stage_n;
    logic       seq_done;
    logic [1:0] seq_state;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_STAGES (3),
        .HOLD_CYCLES(4),
        .LOCK_FILT  (3),
        .STAGE_DLY  (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .sw_rst_req (sw_rst_req),
        .rst_stage_n(rst_stage_n),
        .seq_done   (seq_done),
        .seq_state  (seq_state)
    );

    // Expected {state, stages, done} at relative edge e, given the edges on
    // which LOCK_WAIT and RELEASE are entered (stages 5 edges apart).
    function automatic logic [5:0] expect_at(int e, int lw_at, int rel_at);
        logic [1:0] st;
        logic [2:0] stg;
        logic       dn;
        st  = (e < lw_at) ? 2'd0 : (e < rel_at) ? 2'd1 : (e < rel_at + 15) ? 2'd2 : 2'd3;
        stg = (e < rel_at + 5)  ? 3'b000 :
              (e < rel_at + 10) ? 3'b001 :
              (e < rel_at + 15) ? 3'b011 : 3'b111;
        dn  = (e >= rel_at + 15);
        return {st, stg, dn};
    endfunction

    // Advance one edge, then check the thermometer and done invariants.
    task automatic tick();
        logic [2:0] plus1;
        @(posedge clk);
        #1;
        plus1 = rst_stage_n + 3'd1;
        checks++;
        if ((plus1 & rst_stage_n) !== 3'b000 || (seq_done === 1'b1 && rst_stage_n !== 3'b111)) begin
            $display("FAIL invariant t=%0t stages=%b done=%b required thermometer, done only with 111",
                     $time, rst_stage_n, seq_done);
            fails++;
        end
    endtask

    task automatic test_reset();
        pll_locked = 1'b1;
        sw_rst_req = 1'b0;
        rst_n      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({seq_state, rst_stage_n, seq_done} !== 6'b0) begin
                $display("FAIL reset cyc=%0d got state=%0d stages=%b done=%b required 0/000/0",
                         i, seq_state, rst_stage_n, seq_done);
                fails++;
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lock_filter();
        logic [5:0] pat;
        logic [5:0] exp;
        pat        = 6'b111011;
        pll_locked = 1'b0;
        rst_n      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 27; e++) begin
            if (e >= 5 && e <= 10) pll_locked = pat[e-5];
            tick();
            exp = expect_at(e, 4, 12);
            checks++;
            if ({seq_state, rst_stage_n, seq_done} !== exp) begin
                $display("FAIL lock_filter e=%0d got state=%0d stages=%b done=%b required %0d/%b/%b",
                         e, seq_state, rst_stage_n, seq_done, exp[5:4], exp[3:1], exp[0]);
                fails++;
            end
        end
        pll_locked = 1'b1;
    endtask

    task automatic test_nominal();
        logic [5:0] exp;
        pll_locked = 1'b1;
        rst_n      = 1'b0;
        repeat (5) tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            tick();
            exp = expect_at(e, 4, 7);
            checks++;
            if ({seq_state, rst_stage_n, seq_done} !== exp) begin
                $display("FAIL nominal e=%0d got state=%0d stages=%b done=%b required %0d/%b/%b",
                         e, seq_state, rst_stage_n, seq_done, exp[5:4], exp[3:1], exp[0]);
                fails++;
            end
        end
    endtask

    task automatic test_lock_loss();
        logic [5:0] exp;
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        checks++;
        if ({seq_state, rst_stage_n, seq_done} !== 6'b11_111_1) begin
            $display("FAIL lock_loss_sync got state=%0d stages=%b done=%b required 3/111/1",
                     seq_state, rst_stage_n, seq_done);
            fails++;
        end
        for (int e = 3; e <= 27; e++) begin
            if (e > 3) tick();
            else tick();
            exp = expect_at(e, 7, 10);
            checks++;
            if ({seq_state, rst_stage_n, seq_done} !== exp) begin
                $display("FAIL lock_loss e=%0d got state=%0d stages=%b done=%b required %0d/%b/%b",
                         e, seq_state, rst_stage_n, seq_done, exp[5:4], exp[3:1], exp[0]);
                fails++;
            end
        end
    endtask

    task automatic test_sw_rst_req();
        logic [5:0] exp;
        for (int e = 1; e <= 13; e++) begin
            sw_rst_req = (e == 1);
            tick();
            sw_rst_req = 1'b0;
            exp = expect_at(e, 5, 8);
            checks++;
            if ({seq_state, rst_stage_n, seq_done} !== exp) begin
                $display("FAIL sw_from_run e=%0d got state=%0d stages=%b done=%b required %0d/%b/%b",
                         e, seq_state, rst_stage_n, seq_done, exp[5:4], exp[3:1], exp[0]);
                fails++;
            end
        end
        // Now mid-RELEASE with stage 0 out; a second pulse in HOLD restarts the hold.
        for (int f = 1; f <= 27; f++) begin
            sw_rst_req = (f == 1 || f == 3);
            tick();
            sw_rst_req = 1'b0;
            exp = expect_at(f, 7, 10);
            checks++;
            if ({seq_state, rst_stage_n, seq_done} !== exp) begin
                $display("FAIL sw_mid_release f=%0d got state=%0d stages=%b done=%b required %0d/%b/%b",
                         f, seq_state, rst_stage_n, seq_done, exp[5:4], exp[3:1], exp[0]);
                fails++;
            end
        end
    endtask

    task automatic test_sync_reset();
        logic [5:0] exp;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({seq_state, rst_stage_n, seq_done} !== 6'b0) begin
            $display("FAIL sync_reset_edge got state=%0d stages=%b done=%b required 0/000/0",
                     seq_state, rst_stage_n, seq_done);
            fails++;
        end
        for (int e = 1; e <= 24; e++) begin
            tick();
            exp = expect_at(e, 4, 7);
            checks++;
            if ({seq_state, rst_stage_n, seq_done} !== exp) begin
                $display("FAIL sync_reset e=%0d got state=%0d stages=%b done=%b required %0d/%b/%b",
                         e, seq_state, rst_stage_n, seq_done, exp[5:4], exp[3:1], exp[0]);
                fails++;
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [5:0] exp;
        for (int e = 1; e <= 24; e++) begin
            sw_rst_req = (e == 1);
            pll_locked = (e != 1);
            tick();
            sw_rst_req = 1'b0;
            pll_locked = 1'b1;
            exp = expect_at(e, 5, 8);
            checks++;
            if ({seq_state, rst_stage_n, seq_done} !== exp) begin
                $display("FAIL simultaneous e=%0d got state=%0d stages=%b done=%b required %0d/%b/%b",
                         e, seq_state, rst_stage_n, seq_done, exp[5:4], exp[3:1], exp[0]);
                fails++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_filter();
        test_nominal();
        test_lock_loss();
        test_sw_rst_req();
        test_sync_reset();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
